// File: rtl/trigger_fsm_mc_pkg.sv
// Shared types and constants for the multi-channel ADC trigger FSM.
// State encodings are visible on state_out, so they are fixed here.
package trig_fsm_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_DELAY   = 2'd2,
    S_CAPTURE = 2'd3
  } state_e;

  localparam int N_CH_DEF  = 2;
  localparam int ADC_W_DEF = 14;
  localparam int CNT_W_DEF = 24;
  localparam int DLY_W_DEF = 8;
  localparam int MISSED_W  = 16;

  // Saturating increment for the missed-trigger counter.
  function automatic logic [MISSED_W-1:0] sat_inc(
    input logic [MISSED_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/trigger_fsm_mc_if.sv
// ADC/config/capture bundle between the trigger FSM and its neighbours.
// master drives ADC data and controls; slave is the FSM itself.
interface trigger_fsm_mc_if
  import trig_fsm_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int ADC_W = ADC_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DLY_W = DLY_W_DEF
) ();

  logic [N_CH*ADC_W-1:0] adc_data;
  logic                  trig;
  logic                  sniff_trig;
  logic                  abort;
  logic [CNT_W-1:0]      max_sample_cnt;
  logic [CNT_W-1:0]      max_repetition_cnt;
  logic [DLY_W-1:0]      trig_delay;
  logic [DLY_W-1:0]      decim;

  logic [N_CH*ADC_W-1:0] data_out;
  logic                  write_enable;
  logic [CNT_W-1:0]      sample_idx;
  logic                  run_done;
  logic [MISSED_W-1:0]   missed_trig;
  logic [1:0]            state_out;

  modport master (
    output adc_data, trig, sniff_trig, abort,
    output max_sample_cnt, max_repetition_cnt,
    output trig_delay, decim,
    input  data_out, write_enable, sample_idx,
    input  run_done, missed_trig, state_out
  );

  modport slave (
    input  adc_data, trig, sniff_trig, abort,
    input  max_sample_cnt, max_repetition_cnt,
    input  trig_delay, decim,
    output data_out, write_enable, sample_idx,
    output run_done, missed_trig, state_out
  );

endinterface

// File: rtl/trigger_fsm_mc_edge_det.sv
// Registered rising-edge detector for the external trigger.
// History resets high so a trigger held through reset is not an edge.
module trig_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  output logic rise
);

  logic trig_d;
  logic trig_q;

  assign trig_d = trig;
  assign rise   = trig & ~trig_q;

  // Previous-cycle trigger level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) trig_q <= 1'b1;
    else     trig_q <= trig_d;
  end

endmodule

// File: rtl/trigger_fsm_mc.sv
// Multi-channel trigger FSM: arm, wait for edge, delay, capture a
// decimated record from all channels, repeat for the programmed count.
module trigger_fsm_mc
  import trig_fsm_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int ADC_W = ADC_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DLY_W = DLY_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  trigger_fsm_mc_if.slave  bus
);

  localparam int DW = N_CH * ADC_W;

  state_e state_q, state_d;

  logic [CNT_W-1:0]    shmax_q, shmax_d;
  logic [DLY_W-1:0]    shdly_q, shdly_d;
  logic [DLY_W-1:0]    shdec_q, shdec_d;
  logic [CNT_W-1:0]    rep_q, rep_d;
  logic [CNT_W-1:0]    smp_q, smp_d;
  logic [DLY_W-1:0]    dly_q, dly_d;
  logic [DLY_W-1:0]    dec_q, dec_d;
  logic [DW-1:0]       dout_q, dout_d;
  logic                we_q, we_d;
  logic [CNT_W-1:0]    sidx_q, sidx_d;
  logic                done_q, done_d;
  logic [MISSED_W-1:0] miss_q, miss_d;

  logic rise;
  logic rep_zero, smp_zero, dly_zero, dec_zero;

  trig_edge_det u_edge (
    .clk  (clk),
    .rst  (rst),
    .trig (bus.trig),
    .rise (rise)
  );

  assign rep_zero = (rep_q == '0);
  assign smp_zero = (smp_q == '0);
  assign dly_zero = (dly_q == '0);
  assign dec_zero = (dec_q == '0);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state; abort wins over every transition.
  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:
          if (bus.sniff_trig) state_d = S_ARMED;
        S_ARMED:
          if (rep_zero)  state_d = S_IDLE;
          else if (rise) state_d = S_DELAY;
        S_DELAY:
          if (dly_zero) state_d = S_CAPTURE;
        S_CAPTURE:
          if (dec_zero && smp_zero) state_d = S_ARMED;
        default: ;
      endcase
    end
  end

  // Counters, shadow config and capture outputs; abort holds them all.
  always_comb begin
    shmax_d = shmax_q;
    shdly_d = shdly_q;
    shdec_d = shdec_q;
    rep_d   = rep_q;
    smp_d   = smp_q;
    dly_d   = dly_q;
    dec_d   = dec_q;
    dout_d  = dout_q;
    sidx_d  = sidx_q;
    miss_d  = miss_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    if (!bus.abort) begin
      unique case (state_q)
        S_IDLE:
          if (bus.sniff_trig) begin
            shmax_d = bus.max_sample_cnt;
            rep_d   = bus.max_repetition_cnt;
            shdly_d = bus.trig_delay;
            shdec_d = bus.decim;
            miss_d  = '0;
          end
        S_ARMED:
          if (rep_zero)  done_d = 1'b1;
          else if (rise) dly_d  = shdly_q;
        S_DELAY: begin
          if (rise) miss_d = sat_inc(miss_q);
          if (dly_zero) begin
            dout_d = bus.adc_data;
            we_d   = 1'b1;
            sidx_d = '0;
            smp_d  = shmax_q;
            dec_d  = shdec_q;
          end else begin
            dly_d = dly_q - 1'b1;
          end
        end
        S_CAPTURE: begin
          if (rise) miss_d = sat_inc(miss_q);
          if (!dec_zero) begin
            dec_d = dec_q - 1'b1;
          end else if (smp_zero) begin
            rep_d = rep_q - 1'b1;
          end else begin
            dout_d = bus.adc_data;
            we_d   = 1'b1;
            sidx_d = sidx_q + 1'b1;
            smp_d  = smp_q - 1'b1;
            dec_d  = shdec_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shmax_q <= '0;
      shdly_q <= '0;
      shdec_q <= '0;
      rep_q   <= '0;
      smp_q   <= '0;
      dly_q   <= '0;
      dec_q   <= '0;
      dout_q  <= '0;
      we_q    <= 1'b0;
      sidx_q  <= '0;
      done_q  <= 1'b0;
      miss_q  <= '0;
    end else begin
      shmax_q <= shmax_d;
      shdly_q <= shdly_d;
      shdec_q <= shdec_d;
      rep_q   <= rep_d;
      smp_q   <= smp_d;
      dly_q   <= dly_d;
      dec_q   <= dec_d;
      dout_q  <= dout_d;
      we_q    <= we_d;
      sidx_q  <= sidx_d;
      done_q  <= done_d;
      miss_q  <= miss_d;
    end
  end

  assign bus.data_out     = dout_q;
  assign bus.write_enable = we_q;
  assign bus.sample_idx   = sidx_q;
  assign bus.run_done     = done_q;
  assign bus.missed_trig  = miss_q;
  assign bus.state_out    = state_q;

endmodule
